// File: rtl/riscv_wb_load_unit_pkg.sv
// Shared definitions for the writeback load unit.
//   load_type_e : funct3 encodings of the supported loads.
//   state_e     : writeback load FSM states.
//   load_ok()   : true when a load type is legal and its address is naturally aligned.
package riscv_wb_load_unit_pkg;

  localparam int unsigned LoadTypeBus = 3;

  typedef enum logic [LoadTypeBus-1:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic load_ok(input logic [LoadTypeBus-1:0] t, input logic [1:0] off);
    case (t)
      LB, LBU: return 1'b1;
      LH, LHU: return ~off[0];
      LW:      return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_wb_load_unit_extend.sv
// riscv_load_extend: combinational lane select and sign/zero extension of a
// returned bus word.
//   load_type_i : funct3 of the load
//   offset_i    : byte offset within the word (addr[1:0])
//   rdata_i     : raw 32-bit bus word
//   data_o      : value to write to the register file
module riscv_load_extend
  import riscv_wb_load_unit_pkg::*;
(
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{offset_i, 3'b000} +: 8];
    half_v = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = '0;
    case (load_type_i)
      LB:      data_o = {{24{byte_v[7]}}, byte_v};
      LBU:     data_o = {24'b0, byte_v};
      LH:      data_o = {{16{half_v[15]}}, half_v};
      LHU:     data_o = {16'b0, half_v};
      LW:      data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/riscv_wb_load_unit.sv
// riscv_wb_load_unit: writeback-stage load unit. Issues a req/ack bus read for
// loads held in MEM/WB, extends the returned data and drives the register-file
// write port; non-load results pass straight through.
//   clk, rst_n            : clock, asynchronous active-low reset
//   rd_idx_i/rd_we_i      : destination register from MEM/WB
//   data_addr_i/data_re_i : load address / load flag
//   load_type_i           : funct3 of the load
//   alu_result_i          : writeback value for non-loads
//   mem_*                 : data-memory bus (req held until ack)
//   wb_we_o/idx_o/data_o  : registered register-file write port
//   stall_req_o           : freeze earlier stages while a load is outstanding
//   load_fault_o          : one-cycle fault pulse (misaligned/illegal/error/timeout)
module riscv_wb_load_unit
  import riscv_wb_load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_idx_i,
  input  logic        rd_we_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_re_i,
  input  logic [2:0]  load_type_i,
  input  logic [31:0] alu_result_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        wb_we_o,
  output logic [4:0]  wb_idx_o,
  output logic [31:0] wb_data_o,
  output logic        stall_req_o,
  output logic        load_fault_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       lat_idx_q;
  logic             lat_we_q;
  logic [2:0]       lat_type_q;
  logic [1:0]       lat_off_q;
  logic [31:0]      ext_data;

  riscv_load_extend u_extend (
    .load_type_i (lat_type_q),
    .offset_i    (lat_off_q),
    .rdata_i     (mem_rdata_i),
    .data_o      (ext_data)
  );

  // DONE is deliberately not stalled so MEM/WB retires the finished load.
  assign stall_req_o = ((state_q == ST_IDLE) && data_re_i) || (state_q == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lat_idx_q    <= '0;
      lat_we_q     <= 1'b0;
      lat_type_q   <= '0;
      lat_off_q    <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      wb_we_o      <= 1'b0;
      wb_idx_o     <= '0;
      wb_data_o    <= '0;
      load_fault_o <= 1'b0;
    end else begin
      // Write enable and fault are single-cycle pulses unless re-asserted below.
      wb_we_o      <= 1'b0;
      load_fault_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!data_re_i) begin
            wb_we_o   <= rd_we_i && (rd_idx_i != '0);
            wb_idx_o  <= rd_idx_i;
            wb_data_o <= alu_result_i;
          end else if (load_ok(load_type_i, data_addr_i[1:0])) begin
            state_q    <= ST_WAIT;
            mem_req_o  <= 1'b1;
            mem_addr_o <= {data_addr_i[31:2], 2'b00};
            lat_idx_q  <= rd_idx_i;
            lat_we_q   <= rd_we_i;
            lat_type_q <= load_type_i;
            lat_off_q  <= data_addr_i[1:0];
            cnt_q      <= '0;
          end else begin
            state_q      <= ST_DONE;
            load_fault_o <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            state_q   <= ST_DONE;
            mem_req_o <= 1'b0;
            if (mem_err_i) begin
              load_fault_o <= 1'b1;
            end else begin
              wb_we_o   <= lat_we_q && (lat_idx_q != '0);
              wb_idx_o  <= lat_idx_q;
              wb_data_o <= ext_data;
            end
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= ST_DONE;
            mem_req_o    <= 1'b0;
            load_fault_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_wb_load_unit.sv
// Self-checking bench for riscv_wb_load_unit: directed and randomized loads and
// pass-through writes against a behavioural model of the load rules.
module tb_riscv_wb_load_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rd_idx_i;
  logic        rd_we_i;
  logic [31:0] data_addr_i;
  logic        data_re_i;
  logic [2:0]  load_type_i;
  logic [31:0] alu_result_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;
  logic        wb_we_o;
  logic [4:0]  wb_idx_o;
  logic [31:0] wb_data_o;
  logic        stall_req_o;
  logic        load_fault_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_wb_load_unit #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_idx_i     (rd_idx_i),
    .rd_we_i      (rd_we_i),
    .data_addr_i  (data_addr_i),
    .data_re_i    (data_re_i),
    .load_type_i  (load_type_i),
    .alu_result_i (alu_result_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .wb_we_o      (wb_we_o),
    .wb_idx_o     (wb_idx_o),
    .wb_data_o    (wb_data_o),
    .stall_req_o  (stall_req_o),
    .load_fault_o (load_fault_o)
  );

  // Access size in bytes for a funct3 (0 = illegal).
  function automatic int load_size(input logic [2:0] t);
    case (t)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Reference value: shift the word down by the byte offset, keep `size` bytes,
  // and for signed types subtract 2^(8*size) when the top bit is set.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    longint v;
    longint span;
    int sz;
    sz = load_size(t);
    v = longint'({32'b0, w} >> (8 * int'(off)));
    if (sz < 4) begin
      span = longint'(1) << (8 * sz);
      v = v % span;
      if ((t == 3'd0 || t == 3'd1) && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  task automatic test_reset;
    vectors++;
    if ({mem_req_o, wb_we_o, load_fault_o, stall_req_o} !== 4'b0 || mem_addr_o !== 32'h0 ||
        wb_idx_o !== 5'h0 || wb_data_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: got req=%b we=%b flt=%b stall=%b addr=%h idx=%0d data=%h, expected all zero",
               mem_req_o, wb_we_o, load_fault_o, stall_req_o, mem_addr_o, wb_idx_o, wb_data_o);
    end
  endtask

  // ack_at: WAIT cycle (1-based) carrying the ack; 0 or >TIMEOUT means no ack.
  task automatic run_load(input logic [2:0] t, input logic [31:0] addr, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic we, input int ack_at, input logic err);
    int sz;
    bit ok;
    bit acked;
    int nwait;
    logic exp_we;
    logic exp_flt;
    sz = load_size(t);
    ok = (sz != 0) && ((addr % sz) == 0);
    acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
    nwait = acked ? ack_at : TIMEOUT;

    @(posedge clk); #1;
    data_re_i = 1'b1; load_type_i = t; data_addr_i = addr;
    rd_idx_i = rd; rd_we_i = we; alu_result_i = $urandom;
    @(negedge clk);
    vectors++;
    if (stall_req_o !== 1'b1 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL load_issue: got stall=%b req=%b, expected stall=1 req=0", stall_req_o, mem_req_o);
    end

    if (!ok) begin
      @(negedge clk);
      vectors++;
      if ({mem_req_o, stall_req_o, wb_we_o, load_fault_o} !== 4'b0001) begin
        miscompares++;
        $display("FAIL bad_load_done: t=%0d addr=%h got req/stall/we/flt=%b, expected 0001",
                 t, addr, {mem_req_o, stall_req_o, wb_we_o, load_fault_o});
      end
    end else begin
      for (int i = 1; i <= nwait; i++) begin
        @(negedge clk);
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== (addr & 32'hFFFF_FFFC) || stall_req_o !== 1'b1 ||
            wb_we_o !== 1'b0 || load_fault_o !== 1'b0) begin
          miscompares++;
          $display("FAIL wait_cycle%0d: got req=%b addr=%h stall=%b we=%b flt=%b, expected req=1 addr=%h stall=1 we=0 flt=0",
                   i, mem_req_o, mem_addr_o, stall_req_o, wb_we_o, load_fault_o, addr & 32'hFFFF_FFFC);
        end
        if (acked && i == nwait) begin
          mem_ack_i = 1'b1; mem_rdata_i = rdata; mem_err_i = err;
        end else begin
          mem_ack_i = 1'b0; mem_rdata_i = $urandom; mem_err_i = 1'($urandom);
        end
      end
      @(posedge clk); #1;
      mem_ack_i = 1'b0; mem_err_i = 1'b0;
      @(negedge clk);
      exp_flt = !acked || err;
      exp_we = acked && !err && we && (rd != 5'd0);
      vectors++;
      if ({mem_req_o, stall_req_o, wb_we_o, load_fault_o} !== {2'b00, exp_we, exp_flt}) begin
        miscompares++;
        $display("FAIL load_done: t=%0d addr=%h got req/stall/we/flt=%b, expected %b",
                 t, addr, {mem_req_o, stall_req_o, wb_we_o, load_fault_o}, {2'b00, exp_we, exp_flt});
      end
      if (exp_we) begin
        vectors++;
        if (wb_idx_o !== rd || wb_data_o !== ref_load(t, addr[1:0], rdata)) begin
          miscompares++;
          $display("FAIL load_data: t=%0d addr=%h rdata=%h got idx=%0d data=%h, expected idx=%0d data=%h",
                   t, addr, rdata, wb_idx_o, wb_data_o, rd, ref_load(t, addr[1:0], rdata));
        end
      end
    end

    // MEM/WB advances past the load; DONE must not have restarted anything.
    @(posedge clk); #1;
    data_re_i = 1'b0; rd_we_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_req_o, stall_req_o, wb_we_o, load_fault_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL after_done: got req/stall/we/flt=%b, expected 0000",
               {mem_req_o, stall_req_o, wb_we_o, load_fault_o});
    end
  endtask

  task automatic test_passthrough(input logic [4:0] rd, input logic we, input logic [31:0] val);
    @(posedge clk); #1;
    data_re_i = 1'b0; rd_idx_i = rd; rd_we_i = we; alu_result_i = val;
    load_type_i = 3'($urandom); data_addr_i = $urandom;
    @(negedge clk);
    vectors++;
    if (stall_req_o !== 1'b0 || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_nostall: got stall=%b req=%b, expected 0 0", stall_req_o, mem_req_o);
    end
    @(posedge clk); #1;
    rd_we_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (wb_we_o !== (we && rd != 5'd0) || wb_idx_o !== rd || wb_data_o !== val || load_fault_o !== 1'b0) begin
      miscompares++;
      $display("FAIL passthrough: got we=%b idx=%0d data=%h flt=%b, expected we=%b idx=%0d data=%h flt=0",
               wb_we_o, wb_idx_o, wb_data_o, load_fault_o, we && rd != 5'd0, rd, val);
    end
  endtask

  task automatic test_directed;
    run_load(3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 5'd5, 1'b1, 3, 1'b0);   // LW
    run_load(3'd0, 32'h0000_0103, 32'h80FF_FF00, 5'd6, 1'b1, 1, 1'b0);   // LB  -> FFFFFF80
    run_load(3'd4, 32'h0000_0103, 32'h80FF_FF00, 5'd6, 1'b1, 2, 1'b0);   // LBU -> 00000080
    run_load(3'd5, 32'h0000_0102, 32'h80FF_FF00, 5'd9, 1'b1, 1, 1'b0);   // LHU -> 000080FF
    run_load(3'd1, 32'h0000_0102, 32'h80FF_FF00, 5'd9, 1'b1, 1, 1'b0);   // LH  -> FFFF80FF
    run_load(3'd1, 32'h0000_0201, 32'h1234_5678, 5'd3, 1'b1, 1, 1'b0);   // misaligned LH
    run_load(3'd2, 32'h0000_0202, 32'h1234_5678, 5'd3, 1'b1, 1, 1'b0);   // misaligned LW
    run_load(3'd3, 32'h0000_0100, 32'h1234_5678, 5'd3, 1'b1, 1, 1'b0);   // illegal funct3
    run_load(3'd2, 32'h0000_0400, 32'h1111_2222, 5'd4, 1'b1, 2, 1'b1);   // bus error
    run_load(3'd2, 32'h0000_0100, 32'hCAFE_F00D, 5'd0, 1'b1, 1, 1'b0);   // rd = x0
    test_passthrough(5'd7, 1'b1, 32'h0000_1234);
    test_passthrough(5'd0, 1'b1, 32'h0000_5678);
    test_passthrough(5'd8, 1'b0, 32'h0000_9ABC);
  endtask

  task automatic test_timeout;
    run_load(3'd2, 32'h0000_0500, 32'h0, 5'd10, 1'b1, 0, 1'b0);          // never acked
    run_load(3'd2, 32'h0000_0504, 32'h7654_3210, 5'd11, 1'b1, TIMEOUT, 1'b0); // ack on last WAIT cycle
  endtask

  task automatic test_async_reset;
    @(posedge clk); #1;
    data_re_i = 1'b1; load_type_i = 3'd2; data_addr_i = 32'h0000_0300; rd_idx_i = 5'd12; rd_we_i = 1'b1;
    @(posedge clk);   // enter WAIT
    @(posedge clk);   // WAIT cycle 2
    #2;
    rst_n = 1'b0; data_re_i = 1'b0; rd_we_i = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF; mem_err_i = 1'b0;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_req_o, stall_req_o, wb_we_o, load_fault_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL stray_ack: got req/stall/we/flt=%b, expected 0000",
               {mem_req_o, stall_req_o, wb_we_o, load_fault_o});
    end
    run_load(3'd2, 32'h0000_0600, 32'hA5A5_5A5A, 5'd13, 1'b1, 2, 1'b0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        test_passthrough(5'($urandom), 1'($urandom), $urandom);
      end else begin
        logic [31:0] addr;
        int ack_at;
        addr = $urandom;
        if ($urandom_range(1, 0) == 1) addr[1:0] = 2'b00;
        ack_at = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(5, 1));
        run_load(3'($urandom), addr, $urandom, 5'($urandom), 1'($urandom), ack_at,
                 ($urandom_range(5, 0) == 0));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rd_idx_i = '0; rd_we_i = 1'b0; data_addr_i = '0; data_re_i = 1'b0;
    load_type_i = '0; alu_result_i = '0; mem_ack_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_directed();
    test_timeout();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv_wb_load_unit.md
Name: riscv_wb_load_unit

Overview:
- Writeback-side consumer of the MEM/WB pipeline register.
- Takes the latched load request (data_addr, data_re, rd_idx, rd_we) and issues a read on the data-memory bus using a req/ack handshake.
- Aligns and sign- or zero-extends the returned word, then drives the register-file write port.
- Holds stall_req_o so the pipeline controller freezes earlier stages while a load is outstanding; non-load results pass straight through to writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles without mem_ack_i before a load fault is raised.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_idx_i  in  5  destination register index from MEM/WB.
- rd_we_i  in  1  destination write enable from MEM/WB.
- data_addr_i  in  32  load byte address from MEM/WB.
- data_re_i  in  1  instruction in WB is a load.
- load_type_i  in  3  funct3 of the load.
- alu_result_i  in  32  writeback value for non-load instructions.
- mem_req_o  out  1  bus read request, held until ack.
- mem_addr_o  out  32  word-aligned bus address, {addr[31:2],2'b00}.
- mem_ack_i  in  1  bus response valid, one-cycle pulse.
- mem_rdata_i  in  32  bus read data, valid with ack.
- mem_err_i  in  1  bus error, valid with ack.
- wb_we_o  out  1  register-file write enable.
- wb_idx_o  out  5  register-file write index.
- wb_data_o  out  32  register-file write data.
- stall_req_o  out  1  stall request to the pipeline controller.
- load_fault_o  out  1  one-cycle pulse: misaligned, illegal-type, bus-error or timeout load.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; mem_req_o=0, mem_addr_o=0, wb_we_o=0, wb_idx_o=0, wb_data_o=0, load_fault_o=0, counter=0. A reset in WAIT abandons the request immediately; a late ack arriving in IDLE is ignored.
- stall_req_o is combinational: (IDLE and data_re_i) or WAIT. It is low in DONE.
- Writeback outputs are registered and valid one cycle after the source event. wb_we_o is forced to 0 whenever the target index is 0.
- IDLE, data_re_i=0: next cycle wb_we_o=rd_we_i, wb_idx_o=rd_idx_i, wb_data_o=alu_result_i. No stall.
- IDLE, data_re_i=1, legal and aligned: go to WAIT; register mem_req_o=1, mem_addr_o; latch rd_idx_i, rd_we_i, load_type_i, addr[1:0]; clear counter.
- IDLE, data_re_i=1, misaligned or illegal type: go to DONE; no bus request; load_fault_o=1 and wb_we_o=0 in DONE.
  - Misaligned: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - Illegal: funct3 not in {000,001,010,100,101}.
- WAIT, mem_ack_i=1 and mem_err_i=0: go to DONE; mem_req_o=0; wb_we_o=latched rd_we, wb_data_o=extracted value.
- WAIT, mem_ack_i=1 and mem_err_i=1: go to DONE; mem_req_o=0; load_fault_o=1; no writeback.
- WAIT, no ack: counter increments. When counter reaches TIMEOUT_CYCLES-1 without ack, go to DONE with fault and no writeback; mem_req_o drops.
- DONE: lasts exactly one cycle. stall_req_o=0 so MEM/WB advances at the end of this cycle. Inputs, which still present the finished load, are ignored. Next state IDLE. wb_we_o and load_fault_o return to 0 the following cycle unless a new event occurs.
- Extraction uses the latched addr[1:0]:
  - LB/LBU: byte lane addr[1:0].
  - LH/LHU: half lane addr[1].
  - LW: whole word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Load latency: request cycle T0 (IDLE), mem_req_o high from T1, ack at Tk, wb_we_o high at Tk+1 (DONE).

Decomposition:
- riscv_define.v gains:
  - LoadTypeBus [2:0].
  - Load codes LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - FSM state codes IDLE/WAIT/DONE.
- One combinational sub-module, riscv_load_extend, takes (type, addr[1:0], rdata) and returns the 32-bit result.

Test Plan:
- LW at 0x100; ack after 3 WAIT cycles with rdata=0xDEADBEEF, rd=5 -> mem_req_o high 3 cycles, mem_addr_o=0x100, then wb_we_o=1, wb_idx_o=5, wb_data_o=0xDEADBEEF; stall_req_o low in DONE.
- LB at 0x103 with rdata=0x80FF_FF00 -> wb_data_o=0xFFFFFF80. LBU at same -> 0x00000080. LHU at 0x102 -> 0x000080FF.
- LH at 0x201 -> no mem_req_o, load_fault_o pulse, wb_we_o=0, one stall cycle. funct3=3'b011 -> same.
- No ack for 16 cycles -> load_fault_o pulse, mem_req_o drops, wb_we_o=0. mem_err_i with ack -> fault, no write.
- rst_n low in WAIT cycle 2 -> all outputs 0 asynchronously; later stray ack is ignored and state stays IDLE.
- Non-load rd=7, alu_result_i=0x1234 -> wb_we_o=1, data=0x1234 next cycle, no stall. Load with rd=0 -> bus read done, wb_we_o=0.
